// File: rtl/tx_mac.sv
// tx_mac: byte-wide Ethernet transmit MAC emitting preamble, SFD, padded payload, CRC-32 FCS and inter-frame gap
module tx_mac #(
    parameter int         PREAMBLE_LEN = 7,
    parameter logic [7:0] SFD          = 8'hD5,
    parameter int         MIN_FRAME    = 60,
    parameter int         IFG_LEN      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [7:0] tx_dataout,
    output logic       tx_valid,
    output logic       tx_tlast,
    output logic       tx_err,
    output logic       busy
);
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG} state_t;
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    state_t      r_state, w_next;
    logic [15:0] r_tmr;
    logic [10:0] r_cnt, w_cnt_inc;
    logic [31:0] r_crc, w_fcs;
    logic [7:0]  w_byte;
    logic        w_valid, w_last, w_err, w_fold;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) v = v[0] ? (v >> 1) ^ 32'hEDB88320 : v >> 1;
        return v;
    endfunction
    assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    assign w_fcs     = ~r_crc;
    assign s_tready  = (r_state == ST_DATA);
    assign busy      = (r_state != ST_IDLE);
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end
    // outputs are computed from the current state and registered, so every wire byte lags its decision by one edge
    always_comb begin
        w_next  = r_state;
        w_byte  = 8'h00;
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_err   = 1'b0;
        w_fold  = 1'b0;
        case (r_state)
            ST_IDLE: if (s_tvalid) w_next = ST_PRE;
            ST_PRE: begin
                w_byte  = 8'h55;
                w_valid = 1'b1;
                if (r_tmr == PRE_LAST) w_next = ST_SFD;
            end
            ST_SFD: begin
                w_byte  = SFD;
                w_valid = 1'b1;
                w_next  = ST_DATA;
            end
            ST_DATA: begin
                w_valid = 1'b1;
                if (!s_tvalid) begin
                    w_last = 1'b1;
                    w_err  = 1'b1;
                    w_next = ST_IFG;
                end else begin
                    w_byte = s_tdata;
                    w_fold = 1'b1;
                    if (s_tlast) w_next = (w_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                w_valid = 1'b1;
                w_fold  = 1'b1;
                if (w_cnt_inc >= MIN_CNT) w_next = ST_FCS;
            end
            ST_FCS: begin
                w_valid = 1'b1;
                w_byte  = 8'(w_fcs >> {r_tmr[1:0], 3'b000});
                if (r_tmr[1:0] == 2'd3) begin
                    w_last = 1'b1;
                    w_next = ST_IFG;
                end
            end
            ST_IFG: if (r_tmr == IFG_LAST) w_next = s_tvalid ? ST_PRE : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr      <= '0;
            r_cnt      <= '0;
            r_crc      <= '1;
            tx_dataout <= 8'h00;
            tx_valid   <= 1'b0;
            tx_tlast   <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            r_tmr      <= (w_next != r_state) ? '0 : r_tmr + 16'd1;
            r_cnt      <= (r_state == ST_SFD) ? '0 : w_fold ? w_cnt_inc : r_cnt;
            r_crc      <= (r_state == ST_SFD) ? '1 : w_fold ? crc_byte(r_crc, w_byte) : r_crc;
            tx_dataout <= w_byte;
            tx_valid   <= w_valid;
            tx_tlast   <= w_last;
            tx_err     <= w_err;
        end
    end
endmodule

// File: tb/tb_tx_mac.sv
// tb_tx_mac: directed and randomized frames compared cycle by cycle against a frame-level wire model
module tb_tx_mac;
    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MINF = 60;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        rdy_a, val_a, last_a, err_a, busy_a;
    logic        rdy_b, val_b, last_b, err_b, busy_b;
    logic [7:0]  dat_a, dat_b;
    logic        sel = 1'b0;
    logic        mon_on = 1'b0;
    logic        w_rdy, w_val, w_last, w_err, w_busy;
    logic [7:0]  w_dat;
    logic [12:0] obs[$];
    logic [12:0] exp_q[$];
    logic [7:0]  pl[$];
    logic [31:0] tbl[256];
    logic [7:0]  kat[4];
    int checks = 0;
    int errors = 0;
    tx_mac u_dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(rdy_a), .tx_dataout(dat_a), .tx_valid(val_a), .tx_tlast(last_a), .tx_err(err_a), .busy(busy_a)
    );
    tx_mac #(.MIN_FRAME(0)) u_crc (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(rdy_b), .tx_dataout(dat_b), .tx_valid(val_b), .tx_tlast(last_b), .tx_err(err_b), .busy(busy_b)
    );
    always #5 clk = ~clk;
    assign w_rdy  = sel ? rdy_b  : rdy_a;
    assign w_val  = sel ? val_b  : val_a;
    assign w_last = sel ? last_b : last_a;
    assign w_err  = sel ? err_b  : err_a;
    assign w_busy = sel ? busy_b : busy_a;
    assign w_dat  = sel ? dat_b  : dat_a;
    // record layout: {busy while valid, ready, valid, last, err, data while valid}
    always @(negedge clk) if (mon_on) obs.push_back({w_val & w_busy, w_rdy, w_val, w_last, w_err, w_val ? w_dat : 8'h00});
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return tbl[8'(c[7:0] ^ b)] ^ (c >> 8);
    endfunction
    task automatic add_exp(input int n, input int und, input int minf);
        logic [31:0] c;
        logic [7:0]  b;
        logic [9:0]  fr[$];
        int m;
        m = (und >= 0) ? und + 1 : n;
        for (int k = 0; k < PRE; k++) fr.push_back({2'b00, 8'h55});
        fr.push_back({2'b00, 8'hD5});
        if (und >= 0) begin
            for (int k = 0; k < und; k++) fr.push_back({2'b00, pl[k]});
            fr.push_back({2'b11, 8'h00});
        end else begin
            c = '1;
            for (int k = 0; k < ((n > minf) ? n : minf); k++) begin
                b = (k < n) ? pl[k] : 8'h00;
                fr.push_back({2'b00, b});
                c = crc_upd(c, b);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) fr.push_back({k == 3, 1'b0, c[8*k +: 8]});
        end
        foreach (fr[j]) exp_q.push_back({1'b1, (j >= PRE && j <= PRE - 1 + m), 1'b1, fr[j]});
        repeat (IFG) exp_q.push_back(13'd0);
    endtask
    task automatic drive(input int n, input int und, input bit keep);
        int i, lim, cyc;
        logic acc;
        i = 0;
        cyc = 0;
        lim = (und >= 0) ? und : n;
        s_tvalid = 1'b1;
        s_tdata = pl[0];
        s_tlast = (n == 1);
        while (i < lim && cyc < 400) begin
            @(negedge clk);
            acc = w_rdy;
            @(posedge clk);
            #1 cyc++;
            if (acc) begin
                i++;
                if (i < n) begin
                    s_tdata = pl[i];
                    s_tlast = (i == n - 1);
                end
            end
        end
        chk("drv_count", 32'(i), 32'(lim));
        if (und >= 0) s_tvalid = 1'b0;
        else if (!keep) begin
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
        end
    endtask
    task automatic start_window();
        exp_q.delete();
        obs.delete();
        mon_on = 1'b1;
    endtask
    task automatic end_window(input string tag, output int f);
        repeat (120) @(posedge clk);
        #1 mon_on = 1'b0;
        f = -1;
        foreach (obs[i]) if (f < 0 && obs[i][10]) f = i;
        chk({tag, "_start"}, 32'(f >= 0), 32'd1);
        if (f >= 0)
            foreach (exp_q[j])
                chk($sformatf("%s[%0d]", tag, j), (f + j < obs.size()) ? 32'(obs[f + j]) : 32'hDEADBEEF, 32'(exp_q[j]));
    endtask
    task automatic fill(input int n, input bit ramp);
        pl.delete();
        for (int k = 0; k < n; k++) pl.push_back(ramp ? 8'(k) : 8'($urandom));
    endtask
    initial begin
        int f, n, nf, und;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
            tbl[i] = c;
        end
        kat = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(dat_a), 32'd0);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_tlast", 32'(last_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_busy", 32'(busy_a | busy_b), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sel = 1'b1;
        pl.delete();
        for (int k = 0; k < 9; k++) pl.push_back(8'h31 + 8'(k));
        start_window();
        add_exp(9, -1, 0);
        drive(9, -1, 1'b0);
        end_window("crc", f);
        for (int k = 0; k < 4; k++)
            chk($sformatf("kat%0d", k), (f >= 0 && f + 17 + k < obs.size()) ? 32'(obs[f + 17 + k][9:0]) : 32'hDEADBEEF,
                {22'd0, k == 3, 1'b0, kat[k]});
        sel = 1'b0;
        fill(60, 1'b1);
        start_window();
        add_exp(60, -1, MINF);
        drive(60, -1, 1'b0);
        end_window("full", f);
        pl.delete();
        pl.push_back(8'hAB);
        start_window();
        add_exp(1, -1, MINF);
        drive(1, -1, 1'b0);
        end_window("short", f);
        start_window();
        fill(60, 1'b1);
        add_exp(60, -1, MINF);
        drive(60, -1, 1'b1);
        fill(60, 1'b0);
        add_exp(60, -1, MINF);
        drive(60, -1, 1'b0);
        end_window("b2b", f);
        fill(60, 1'b0);
        start_window();
        add_exp(60, 10, MINF);
        drive(60, 10, 1'b0);
        end_window("under", f);
        fill(20, 1'b0);
        start_window();
        add_exp(20, -1, MINF);
        drive(20, -1, 1'b0);
        end_window("after_under", f);
        s_tvalid = 1'b1;
        s_tdata = 8'h5A;
        s_tlast = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_ready", 32'(rdy_a), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_data", 32'(dat_a), 32'd0);
        chk("mid_rst_valid", 32'(val_a), 32'd0);
        chk("mid_rst_tlast", 32'(last_a), 32'd0);
        chk("mid_rst_err", 32'(err_a), 32'd0);
        chk("mid_rst_ready", 32'(rdy_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        s_tvalid = 1'b0;
        fill(60, 1'b0);
        start_window();
        add_exp(60, -1, MINF);
        drive(60, -1, 1'b0);
        end_window("after_rst", f);
        for (int w = 0; w < 8; w++) begin
            nf = $urandom_range(1, 2);
            start_window();
            for (int q = 0; q < nf; q++) begin
                n = $urandom_range(1, 90);
                fill(n, 1'b0);
                und = (nf == 1 && n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
                add_exp(n, und, MINF);
                drive(n, und, q < nf - 1);
            end
            end_window($sformatf("rnd%0d", w), f);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_mac.md
# tx_mac

Byte-wide Ethernet transmit MAC, the transmit-side counterpart of the RX MAC in the market-data path. Accepts a frame payload (destination MAC through end of payload) on an AXI-Stream-style byte interface and emits a complete wire frame on `tx_dataout`:

- preamble and SFD
- payload, zero-padded to the minimum frame size
- IEEE 802.3 CRC-32 FCS
- enforced inter-frame gap

It drives the RMII/byte shim directly, one byte per clock.

## Interface
Parameters
- PREAMBLE_LEN, 7, number of 0x55 preamble bytes (1..15)
- SFD, 8'hD5, start-of-frame delimiter byte
- MIN_FRAME, 60, minimum bytes before FCS; pad with 0x00 up to this (0 disables padding)
- IFG_LEN, 12, idle cycles between frames (≥1)

Ports
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_tdata  in  8  payload byte
- s_tvalid  in  1  payload byte valid
- s_tlast  in  1  marks last payload byte
- s_tready  out  1  MAC accepts s_tdata this cycle
- tx_dataout  out  8  wire byte (registered)
- tx_valid  out  1  tx_dataout is a frame byte (registered)
- tx_tlast  out  1  high with final FCS byte, or with terminating byte on underrun
- tx_err  out  1  one-cycle pulse: frame aborted by underrun
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE:
  - s_tready=0.
  - When s_tvalid=1, go to PREAMBLE. The first payload byte is held by the source, not consumed.
- PREAMBLE: emit 0x55 PREAMBLE_LEN times, then SFD.
- SFD: emit SFD, then DATA.
- DATA:
  - s_tready=1 combinationally from state.
  - Each accepted byte is emitted the next cycle and folded into the CRC.
  - The byte counter (11 bit, saturating at 2047) increments.
  - On accepted s_tlast: go to PAD if count < MIN_FRAME, else FCS.
- PAD: s_tready=0. Emit 0x00, included in CRC and count, until count == MIN_FRAME; then FCS.
- FCS: emit ~CRC, 4 bytes, least-significant byte first. tx_tlast=1 on the 4th byte. Then IFG.
- IFG: tx_valid=0 for exactly IFG_LEN cycles, then IDLE. If s_tvalid=1 on the final IFG cycle, go straight to PREAMBLE.
- CRC definition:
  - Reflected polynomial 0xEDB88320, processed LSB-first, one byte per cycle.
  - Initialised to 0xFFFFFFFF on entry to SFD.
  - Covers payload plus pad only; preamble and SFD are excluded.
- Underrun (DATA with s_tvalid=0, before s_tlast):
  - Next cycle emit 0x00 with tx_valid=1, tx_tlast=1, tx_err=1.
  - No FCS is sent; the receiver's FCS check rejects the frame.
  - Go to IFG.
- s_tlast while s_tvalid=0 is ignored.

## Timing
- Reset values: s_tready=0, tx_dataout=8'h00, tx_valid=0, tx_tlast=0, tx_err=0, busy=0, state=IDLE, counters 0, CRC 0xFFFFFFFF.
- Reset mid-frame: all of the above on the next edge. The frame is truncated with no tx_tlast and no tx_err. The next frame starts with a full preamble.
- Frame timeline (cycle 0 = edge at which IDLE samples s_tvalid=1):
  - Cycles 1..PREAMBLE_LEN: tx_dataout=0x55.
  - Cycle PREAMBLE_LEN+1: SFD.
  - s_tready high from cycle PREAMBLE_LEN+1.
  - Payload byte k appears at cycle PREAMBLE_LEN+2+k when no stall.
- Payload latency: accepted byte to tx_dataout is 1 cycle.
- tx_valid is continuous from first preamble byte to tx_tlast inclusive (underrun excepted).
- Wire length with defaults: 8 + max(N, 60) + 4 tx_valid cycles for an N-byte payload.
- Back-to-back frames: exactly IFG_LEN tx_valid=0 cycles between one tx_tlast and the next frame's first 0x55.

## Test plan
- Reset: assert rst for 2 cycles mid-DATA -> next edge tx_valid=0, s_tready=0, busy=0, tx_dataout=0x00; a fresh frame afterwards starts with 7×0x55.
- CRC check, MIN_FRAME=0: payload ASCII "123456789" (0x31..0x39) -> the following bytes, with tx_tlast only on 0xCB:
  - 7×0x55, 0xD5
  - 0x31..0x39
  - FCS 0x26, 0x39, 0xF4, 0xCB
- Full-size frame: 60-byte payload 0x00..0x3B -> 72 consecutive tx_valid cycles, no PAD state, byte k on wire at cycle 9+k, tx_tlast at cycle 72.
- Short frame: 1-byte payload 0xAB -> 0xAB, then 59×0x00 pad with s_tready=0, then 4 FCS bytes; 72 tx_valid cycles total; FCS equals software CRC-32 of 0xAB followed by 59 zero bytes.
- Back-to-back: two 60-byte frames with s_tvalid held high -> exactly 12 tx_valid=0 cycles between the first tx_tlast and the second preamble; s_tready=0 throughout the gap.
- Underrun: drop s_tvalid after 10 of 60 bytes -> next cycle tx_dataout=0x00, tx_valid=1, tx_tlast=1, tx_err=1; no FCS; then 12 idle cycles; the next frame is transmitted normally.
